// File: rtl/down_counter_reload.sv
// Loadable down-counter/timer with valid/ready load handshake, one-shot or
// auto-reload mode, and a single-cycle registered expiry pulse.
module down_counter_reload #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clk_en,
  input  logic             i_count_valid,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_auto_reload,
  input  logic             i_stop,
  output logic             o_load_ready,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_zero,
  output logic             o_expire,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q,   auto_d;
  logic             expire_q, expire_d;

  logic             load_ready;
  logic             load_fire;
  logic             count_is_one;

  assign load_ready   = (state_q != S_RUN);
  assign load_fire    = i_load_valid & load_ready & i_clk_en;
  assign count_is_one = (count_q == WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    auto_d   = auto_q;
    // Expiry clears on every edge, enabled or not, so it never exceeds one clock.
    expire_d = 1'b0;

    if (load_fire) begin
      count_d  = i_load_value;
      reload_d = i_load_value;
      if (i_load_value == '0) begin
        state_d  = S_DONE;
        expire_d = 1'b1;
        auto_d   = 1'b0;
      end else begin
        state_d  = S_RUN;
        auto_d   = i_auto_reload;
      end
    end else if (i_clk_en) begin
      case (state_q)
        S_RUN: begin
          if (i_stop) begin
            state_d = S_IDLE;
          end else if (i_count_valid) begin
            if (count_is_one) begin
              expire_d = 1'b1;
              if (auto_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          if (i_stop) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      auto_q   <= auto_d;
      expire_q <= expire_d;
    end
  end

  assign o_load_ready = load_ready;
  assign o_count      = count_q;
  assign o_count_zero = (count_q == '0);
  assign o_expire     = expire_q;
  assign o_busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: hand-computed expectations per cycle.
module tb_down_counter_reload;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             resetn;
  logic             i_clk_en;
  logic             i_count_valid;
  logic             i_load_valid;
  logic [WIDTH-1:0] i_load_value;
  logic             i_auto_reload;
  logic             i_stop;
  logic             o_load_ready;
  logic [WIDTH-1:0] o_count;
  logic             o_count_zero;
  logic             o_expire;
  logic             o_busy;

  int unsigned total;
  int unsigned bad;

  down_counter_reload #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_clk_en      (i_clk_en),
    .i_count_valid (i_count_valid),
    .i_load_valid  (i_load_valid),
    .i_load_value  (i_load_value),
    .i_auto_reload (i_auto_reload),
    .i_stop        (i_stop),
    .o_load_ready  (o_load_ready),
    .o_count       (o_count),
    .o_count_zero  (o_count_zero),
    .o_expire      (o_expire),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check count, expire, busy, ready together after the current cycle.
  task automatic chk_all(input string tag, input int c, input bit e, input bit b);
    chk({tag, ".count"},  32'(o_count), 32'(c));
    chk({tag, ".zero"},   32'(o_count_zero), 32'(c == 0));
    chk({tag, ".expire"}, 32'(o_expire), 32'(e));
    chk({tag, ".busy"},   32'(o_busy), 32'(b));
    chk({tag, ".ready"},  32'(o_load_ready), 32'(!b));
  endtask

  task automatic load(input int v, input bit auto_m);
    i_load_valid  = 1'b1;
    i_load_value  = WIDTH'(v);
    i_auto_reload = auto_m;
    tick();
    i_load_valid  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn        = 1'b0;
    i_clk_en      = 1'b0;
    i_count_valid = 1'b0;
    i_load_valid  = 1'b0;
    i_load_value  = '0;
    i_auto_reload = 1'b0;
    i_stop        = 1'b0;

    // 1) reset
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk_all("reset", 0, 0, 0);

    // 2) one-shot load 3
    i_clk_en = 1'b1;
    i_count_valid = 1'b1;
    load(3, 1'b0);
    chk_all("os.ld", 3, 0, 1);
    tick(); chk_all("os.2", 2, 0, 1);
    tick(); chk_all("os.1", 1, 0, 1);
    tick(); chk_all("os.0", 0, 1, 0);
    tick(); chk_all("os.hold", 0, 0, 0);

    // 3) auto-reload 2
    load(2, 1'b1);
    chk_all("ar.ld", 2, 0, 1);
    tick(); chk_all("ar.a1", 1, 0, 1);
    tick(); chk_all("ar.a2", 2, 1, 1);
    tick(); chk_all("ar.a3", 1, 0, 1);
    tick(); chk_all("ar.a4", 2, 1, 1);
    i_stop = 1'b1;
    tick(); chk_all("ar.stop", 2, 0, 0);
    i_stop = 1'b0;

    // 4) qualification by clk_en & count_valid
    i_count_valid = 1'b0;
    load(4, 1'b0);
    chk_all("q.ld", 4, 0, 1);
    i_clk_en = 1'b1; i_count_valid = 1'b0; tick(); chk_all("q.en_only", 4, 0, 1);
    i_clk_en = 1'b0; i_count_valid = 1'b1; tick(); chk_all("q.v_only", 4, 0, 1);
    i_clk_en = 1'b1; i_count_valid = 1'b1; tick(); chk_all("q.both", 3, 0, 1);
    i_clk_en = 1'b0; i_count_valid = 1'b0; tick(); chk_all("q.none", 3, 0, 1);
    i_clk_en = 1'b1; i_count_valid = 1'b1; tick(); chk_all("q.both2", 2, 0, 1);
    i_load_valid = 1'b1; i_load_value = 8'd9;
    tick(); chk_all("q.ld_in_run", 1, 0, 1);
    i_load_valid = 1'b0;
    tick(); chk_all("q.exp", 0, 1, 0);
    i_clk_en = 1'b0;
    tick(); chk_all("q.exp_clr", 0, 0, 0);

    // 5) stop mid-count, then zero load
    i_clk_en = 1'b1;
    i_count_valid = 1'b1;
    load(10, 1'b0);
    chk_all("st.ld", 10, 0, 1);
    repeat (5) tick();
    chk_all("st.5", 5, 0, 1);
    i_stop = 1'b1;
    tick(); chk_all("st.stop", 5, 0, 0);
    tick(); chk_all("st.idle", 5, 0, 0);
    i_stop = 1'b0;
    load(0, 1'b1);
    chk_all("z.ld", 0, 1, 0);
    tick(); chk_all("z.after", 0, 0, 0);

    // 6) async reset mid-count
    load(8, 1'b0);
    repeat (4) tick();
    chk_all("rs.4", 4, 0, 1);
    #2 resetn = 1'b0;
    #1 chk_all("rs.async", 0, 0, 0);
    tick();
    #2 resetn = 1'b1;
    tick(); chk_all("rs.rel1", 0, 0, 0);
    tick(); chk_all("rs.rel2", 0, 0, 0);
    load(5, 1'b0);
    chk_all("rs.reload", 5, 0, 1);
    tick(); chk_all("rs.run", 4, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
